// File: rtl/serial_add_sub_pkg.sv
// Shared constants and types for the bit-serial adder/subtractor and its bench.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit counter width: ceil(log2(width)) + 1
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial add/subtract bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's complement adder/subtractor, LSB first, one bit per clock.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             op_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    logic             sum_d;
    logic             cout_d;
    logic             last_d;
    logic [WIDTH-1:0] res_d;

    // Bit slice: subtract is a + ~b + 1, the +1 coming from the preloaded carry
    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0] ^ op_q),
        .cin   (c_q),
        .sum   (sum_d),
        .carry (cout_d)
    );

    assign res_d  = {sum_d, res_q[WIDTH-1:1]};
    assign last_d = (cnt_q == CW'(WIDTH - 1));

    // Control FSM and serial datapath; flags are captured on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        c_q     <= op;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    c_q   <= cout_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        carry_q <= cout_d;
                        ovf_q   <= c_q ^ cout_d;
                        zero_q  <= (res_d == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       s8, o8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c8, v8, z8;
    logic [7:0] r8;

    logic       s4, o4;
    logic [3:0] a4, b4;
    logic       busy4, done4, c4, v4, z4;
    logic [3:0] r4;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .op(o8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(r8), .carry(c8),
        .overflow(v8), .zero(z8)
    );

    serial_add_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4), .op(o4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(r4), .carry(c4),
        .overflow(v4), .zero(z4)
    );

    // Count one comparison and report it if observed differs from expected
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        o8 = o; a8 = x; b8 = y; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Count busy cycles until done, bounded
    task automatic wait8(output int nb);
        nb = 0;
        for (int i = 0; i < 40 && !done8; i++) begin
            if (busy8) nb++;
            @(negedge clk);
        end
        if (!done8) check("timeout8", 32'd0, 32'd1);
    endtask

    task automatic op8(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ec, input logic ev, input logic ez);
        int nb;
        launch8(o, x, y);
        wait8(nb);
        check({tag, "_busycyc"}, nb, 8);
        check({tag, "_res"}, r8, er);
        check({tag, "_carry"}, c8, ec);
        check({tag, "_ovf"}, v8, ev);
        check({tag, "_zero"}, z8, ez);
    endtask

    task automatic op4(input logic o, input logic [3:0] x, input logic [3:0] y);
        int nb;
        logic [4:0] full;
        logic [3:0] er;
        logic       ev;
        @(negedge clk);
        o4 = o; a4 = x; b4 = y; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        nb = 0;
        for (int i = 0; i < 20 && !done4; i++) begin
            if (busy4) nb++;
            @(negedge clk);
        end
        if (!done4) check("timeout4", 32'd0, 32'd1);
        if (o == OP_SUB) begin
            full = {1'b0, x} + {1'b0, ~y} + 5'd1;
            er   = full[3:0];
            ev   = (x[3] != y[3]) && (er[3] != x[3]);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            er   = full[3:0];
            ev   = (x[3] == y[3]) && (er[3] != x[3]);
        end
        check($sformatf("w4_busycyc_%0d_%0h_%0h", o, x, y), nb, 4);
        check($sformatf("w4_res_%0d_%0h_%0h", o, x, y), r4, er);
        check($sformatf("w4_carry_%0d_%0h_%0h", o, x, y), c4, full[4]);
        check($sformatf("w4_ovf_%0d_%0h_%0h", o, x, y), v4, ev);
        check($sformatf("w4_zero_%0d_%0h_%0h", o, x, y), z4, (er == 4'd0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int gap;
        rst = 1'b1;
        s8 = 1'b0; o8 = OP_ADD; a8 = '0; b8 = '0;
        s4 = 1'b0; o4 = OP_ADD; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_res", r8, 8'h00);
        check("rst_carry", c8, 1'b0);
        check("rst_ovf", v8, 1'b0);
        check("rst_zero", z8, 1'b0);

        // Directed arithmetic vectors
        op8("add7f01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("done_pulse_one_cycle", done8, 1'b0);
        check("hold_res", r8, 8'h80);
        check("hold_ovf", v8, 1'b1);
        op8("addff01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("sub0507", OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
        op8("sub8001", OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8("sub3333", OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1);

        // Start pulse mid-run is ignored; operand changes do not leak in
        launch8(OP_ADD, 8'h12, 8'h34);
        nb = 0;
        for (int i = 0; i < 40 && !done8; i++) begin
            if (busy8) nb++;
            if (busy8 && nb == 3) begin
                s8 = 1'b1; o8 = OP_SUB; a8 = 8'h01; b8 = 8'h01;
            end
            @(negedge clk);
            s8 = 1'b0;
        end
        if (!done8) check("timeout8", 32'd0, 32'd1);
        check("ign_busycyc", nb, 8);
        check("ign_res", r8, 8'h46);
        check("ign_carry", c8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ign_no_queue_busy", busy8, 1'b0);
        check("ign_hold_res", r8, 8'h46);

        // Reset mid-run aborts and clears everything
        op8("addff01b", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        launch8(OP_ADD, 8'h55, 8'h22);
        nb = 0;
        for (int i = 0; i < 40 && nb < 4; i++) begin
            if (busy8) nb++;
            if (nb < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_res", r8, 8'h00);
        check("abort_carry", c8, 1'b0);
        check("abort_ovf", v8, 1'b0);
        check("abort_zero", z8, 1'b0);
        @(negedge clk);
        check("abort_idle", busy8, 1'b0);
        op8("add1020", OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);

        // Start held high relaunches every WIDTH+2 cycles
        @(negedge clk);
        o8 = OP_ADD; a8 = 8'h01; b8 = 8'h02; s8 = 1'b1;
        for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
        check("hold_start_done", done8, 1'b1);
        check("hold_start_res", r8, 8'h03);
        gap = 0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                gap = i;
                break;
            end
        end
        check("hold_start_gap", gap, 10);
        s8 = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive WIDTH=4 sweep
        for (int o = 0; o < 2; o++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(1'(o), 4'(x), 4'(y));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
REQ-006 a  input  WIDTH  first operand, two's complement or unsigned; captured with start.
REQ-007 b  input  WIDTH  second operand; captured with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  WIDTH  sum or difference.
REQ-011 carry  output  1  raw carry out of MSB; for subtract, carry=1 means no borrow.
REQ-012 overflow  output  1  signed overflow flag.
REQ-013 zero  output  1  high when result == 0.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge accepting start: latch a, b and op into shift registers, clear bit counter, load carry flip-flop with op.
REQ-016 Each RUN cycle processes one bit LSB-first: s = a_i XOR (b_i XOR op) XOR c; c <= majority(a_i, b_i XOR op, c); s shifts into result MSB end.
REQ-017 Bit counter runs 0..WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-018 Latency: start accepted at edge k -> done high for the cycle following edge k+WIDTH+1 is NOT used; done SHALL be high exactly in the cycle after edge k+WIDTH (the DONE state), busy high in the WIDTH cycles before it.
REQ-019 overflow = carry into MSB XOR carry out of MSB, captured on the final RUN cycle.
REQ-020 carry, overflow, zero and result SHALL hold their values from DONE until the next accepted start; result register SHALL not show partial values outside RUN.
REQ-021 start while in RUN or DONE SHALL be ignored (no restart, no queuing).
REQ-022 start held high continuously SHALL launch a new operation on each return to IDLE (one idle cycle between operations).
REQ-023 Changes to a, b, op after capture SHALL not affect the running operation.

Reset
REQ-024 rst high at any edge, including mid-RUN, SHALL force IDLE, abort the operation, and clear busy, done, result, carry, overflow, zero (zero output reads 1 since result is 0 is NOT applied: zero SHALL reset to 0).
REQ-025 rst has priority over start on the same edge.

Structure
REQ-026 State encoding and op encoding constants (OP_ADD=0, OP_SUB=1) SHALL live in a shared package used by this block and its bench.
REQ-027 The per-bit sum/carry logic SHALL be an instance of the existing full_adder sub-module (ports a, b, cin, sum, carry); no other sub-modules.
REQ-028 Datapath: two WIDTH-bit operand shift registers, one WIDTH-bit result shift register, carry flip-flop, counter of ceil(log2(WIDTH))+1 bits.

Verification
REQ-029 WIDTH=8, add 0x7F+0x01 -> result 0x80, carry 0, overflow 1, zero 0, done after 8 busy cycles.
REQ-030 WIDTH=8, add 0xFF+0x01 -> result 0x00, carry 1, overflow 0, zero 1.
REQ-031 WIDTH=8, sub 0x05-0x07 -> result 0xFE, carry 0 (borrow), overflow 0; sub 0x80-0x01 -> 0x7F, carry 1, overflow 1.
REQ-032 Pulse start again at busy cycle 3 with different operands -> ignored; original result delivered unchanged.
REQ-033 Assert rst at busy cycle 4 -> next cycle IDLE, all outputs 0; subsequent 0x10+0x20 -> 0x30 correct.
REQ-034 WIDTH=4, exhaustive a, b, op (512 cases) vs behavioural model -> all result/carry/overflow/zero match.
